pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

16-channel PWM/static output stage placed directly downstream of the SPI register file. It consumes the five configuration bytes written over SPI: output enables, PWM-mode enables and one shared duty cycle. It drives 16 registered output pins with about 3 kHz PWM, or static levels, from the 10 MHz system clock. A period-start strobe is provided for the top level and for verification.

## Interface
- `CLK_DIV`, default 13: prescaler ratio (≥1). PWM period = 256·CLK_DIV clk cycles (3328 cycles, about 3.0 kHz at 10 MHz).
- `clk`  in  1  system clock, 10 MHz
- `rst_n`  in  1  reset: asynchronous, active-low
- `en_reg_out_7_0`  in  8  output enable, channels 7..0
- `en_reg_out_15_8`  in  8  output enable, channels 15..8
- `en_reg_pwm_7_0`  in  8  PWM-mode select, channels 7..0
- `en_reg_pwm_15_8`  in  8  PWM-mode select, channels 15..8
- `pwm_duty_cycle`  in  8  shared duty: 0x00 = 0 %, 0xFF = 100 %
- `pwm_out`  out  16  channel outputs; bit i = channel i
- `period_start`  out  1  one-clk pulse at the first cycle of each PWM period

## Operation
- Inputs are synchronous to `clk` and are used directly, with no synchronizers.
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick` = (div_cnt == CLK_DIV-1). With CLK_DIV=1, `tick` is always high.
- PWM counter `pwm_cnt`: 8 bits, increments on `tick`, wraps 255→0. It is never compared against a value above 255.
- Raw PWM level: `pwm_lvl` = 1 if duty_active == 0xFF, else (pwm_cnt < duty_active).
  - Unsigned 8-bit compare.
  - duty 0x00 → constantly 0.
  - duty 0xFF → constantly 1, with no 1-step glitch.
  - Otherwise high for duty·CLK_DIV cycles per period.
- Per channel i, next value:
  - en_out[i]=0 → 0.
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → `pwm_lvl`.
- en_pwm is ignored when en_out=0.
- Enables are never shadowed; an enable change takes effect on the next clock edge.
- `period_start` is registered. It is asserted for exactly one clk, in the first cycle where pwm_cnt == 0 after a wrap from 255.
- Reset values:
  - `pwm_out` = 16'h0000, `period_start` = 0.
  - div_cnt = 0, pwm_cnt = 0, duty_active = 0x00.
- Reset mid-period: all state clears immediately (asynchronous). After release, counting restarts from 0. No `period_start` pulse is issued for the post-reset period.

## Timing
- `pwm_out` is registered.
  - An enable or duty change at the inputs (unshadowed path) appears on `pwm_out` at the 1st clk edge after it is presented.
  - A counter step appears on `pwm_out` at the 1st clk edge after the counter changes.
- pwm_cnt changes only on the edge where `tick`=1.
- A duty change and a counter wrap on the same edge: the new duty applies to the period starting on that edge (see Configuration).
- Steady state: exactly one `period_start` pulse every 256·CLK_DIV cycles.

## Configuration
- Macro: `PWM_DUTY_SYNC_UPDATE_EN`.
- Defined:
  - duty_active is a shadow register, loaded from `pwm_duty_cycle` only on the edge where tick=1 and pwm_cnt==255, i.e. at period wrap.
  - Mid-period duty writes never truncate or extend the current pulse.
  - Latency from duty input to effect is up to one full period plus 1 clk.
- Undefined:
  - duty_active is `pwm_duty_cycle` itself, combinational.
  - A change is visible on `pwm_out` 1 clk later, mid-period glitches allowed.
- Enable paths are identical in both builds.

## Structure
- Package `pwm_pkg`: `PWM_CNT_W` = 8, `PWM_DUTY_FULL` = 8'hFF, `PWM_NUM_CH` = 16, `PWM_CLK_DIV_DEFAULT` = 13.
- One sub-module, `pwm_prescaler`: parameter CLK_DIV; ports clk, rst_n, tick. Its counter width is $clog2(CLK_DIV), minimum 1.
- Top level holds pwm_cnt, duty_active, the output mux/register and `period_start`.

## Test plan
- Reset: assert rst_n=0 mid-period with all enables 0xFF and duty=0x80 → pwm_out=0x0000 and period_start=0 immediately. After release, first period_start arrives 256·13 cycles later.
- Static mode: en_out=0xFFFF, en_pwm=0x0000 → pwm_out=0xFFFF 1 clk later. Set en_out=0x00F0 → pwm_out=0x00F0 next clk.
- Duty 50 %: en_out=en_pwm=0xFFFF, duty=0x80 → each channel high for 128·13=1664 clks, low 1664. period_start interval = 3328.
- Extremes: duty=0x00 → all PWM channels constantly 0. duty=0xFF → constantly 1 across ≥3 periods. Mixed en_pwm=0x00FF, en_out=0xFFFF, duty=0 → pwm_out=0xFF00.
- Sync update (macro defined): at pwm_cnt=0x40 with duty=0x80, write duty=0x10 → current high pulse still lasts 1664 clks. Next period is high for 208 clks.
- Async update (macro undefined): same stimulus → output falls 1 clk after the write, since pwm_cnt ≥ 0x10.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, channel-mode type and PWM level helper for the PWM output stage.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W           = 8;
  localparam logic [7:0]  PWM_DUTY_FULL       = 8'hFF;
  localparam logic [7:0]  PWM_CNT_MAX         = 8'hFF;
  localparam int unsigned PWM_NUM_CH          = 16;
  localparam int unsigned PWM_CLK_DIV_DEFAULT = 13;

  typedef enum logic [1:0] {
    ChOff,
    ChStatic,
    ChPwm
  } ch_mode_e;

  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    if (!en_out) return ChOff;
    return en_pwm ? ChPwm : ChStatic;
  endfunction

  // Full-scale duty is forced high so the counter's 255 step never drops the output.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == PWM_DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a one-cycle tick every CLK_DIV clocks (tick stuck high for CLK_DIV=1).
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] div_cnt_q;

  assign tick = (div_cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM/static output stage with a shared duty cycle and a period-start strobe.
// Define PWM_DUTY_SYNC_UPDATE_EN to shadow the duty cycle and apply it only at period wrap.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_start
);

  logic                  tick;
  logic [PWM_CNT_W-1:0]  pwm_cnt_q;
  logic [PWM_CNT_W-1:0]  duty_active;
  logic                  pwm_lvl;
  logic                  wrap;
  logic [PWM_NUM_CH-1:0] en_out;
  logic [PWM_NUM_CH-1:0] en_pwm;
  logic [PWM_NUM_CH-1:0] pwm_out_d;
  logic [PWM_NUM_CH-1:0] pwm_out_q;
  logic                  period_start_q;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign wrap   = tick && (pwm_cnt_q == PWM_CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else if (tick) begin
      pwm_cnt_q <= pwm_cnt_q + PWM_CNT_W'(1);
    end
  end

`ifdef PWM_DUTY_SYNC_UPDATE_EN
  logic [PWM_CNT_W-1:0] duty_active_q;

  // Loaded on the wrap edge so the new duty governs the period that edge starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_active_q <= '0;
    end else if (wrap) begin
      duty_active_q <= pwm_duty_cycle;
    end
  end

  assign duty_active = duty_active_q;
`else
  assign duty_active = pwm_duty_cycle;
`endif

  assign pwm_lvl = pwm_level(pwm_cnt_q, duty_active);

  always_comb begin
    pwm_out_d = '0;
    for (int unsigned i = 0; i < PWM_NUM_CH; i++) begin
      unique case (ch_mode(en_out[i], en_pwm[i]))
        ChOff:    pwm_out_d[i] = 1'b0;
        ChStatic: pwm_out_d[i] = 1'b1;
        ChPwm:    pwm_out_d[i] = pwm_lvl;
        default:  pwm_out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_out_q      <= pwm_out_d;
      period_start_q <= wrap;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: cycle-by-cycle reference model plus directed period measurements.
module tb_pwm_peripheral;

  localparam int unsigned ClkDiv = 13;
  localparam int unsigned Period = 256 * ClkDiv;

  logic        clk;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] pwm_out;
  logic        period_start;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned n_edges;
`ifdef PWM_DUTY_SYNC_UPDATE_EN
  logic [7:0]  duty_sh;
`endif

  pwm_peripheral #(
    .CLK_DIV (ClkDiv)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .pwm_out         (pwm_out),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, n_edges);
    end
  endtask

  // One clock: predict from elapsed time since reset, then sample 1 time unit after the edge.
  task automatic step();
    logic [15:0] eo, ep, exp_out;
    logic [7:0]  d;
    int unsigned cnt;
    logic        exp_ps;
    eo  = {eo_hi, eo_lo};
    ep  = {ep_hi, ep_lo};
    cnt = (n_edges / ClkDiv) % 256;
`ifdef PWM_DUTY_SYNC_UPDATE_EN
    d = duty_sh;
`else
    d = duty;
`endif
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])      exp_out[i] = 1'b0;
      else if (!ep[i]) exp_out[i] = 1'b1;
      else             exp_out[i] = (d == 8'hFF) ? 1'b1 : (cnt < int'(d));
    end
    exp_ps = ((n_edges + 1) % Period) == 0;
`ifdef PWM_DUTY_SYNC_UPDATE_EN
    if (exp_ps) duty_sh = duty;
`endif
    @(posedge clk);
    n_edges++;
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(exp_out));
    chk("period_start", 32'(period_start), 32'(exp_ps));
  endtask

  task automatic measure(output int unsigned len, output int unsigned hi);
    len = 0;
    hi  = 0;
    do begin
      step();
      len++;
      if (pwm_out[0]) hi++;
    end while (!period_start && len < 4000);
  endtask

  task automatic wait_ps();
    int unsigned len;
    len = 0;
    do begin
      step();
      len++;
    end while (!period_start && len < 4000);
    chk("period_start_bound", 32'(period_start), 32'd1);
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  initial begin
    int unsigned len, hi, len2, hi2;
    n_checks = 0;
    n_fail   = 0;
    n_edges  = 0;
    rst_n    = 1'b0;
    set_en(16'h0000, 16'h0000);
    duty     = 8'h00;
`ifdef PWM_DUTY_SYNC_UPDATE_EN
    duty_sh  = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pwm_out", 32'(pwm_out), 32'h0);
    chk("reset_period_start", 32'(period_start), 32'h0);
    #1 rst_n = 1'b1;

    // Mid-period asynchronous reset with outputs driven high.
    set_en(16'hFFFF, 16'h00FF);
    duty = 8'h80;
    repeat (500) step();
    chk("pre_reset_high", 32'(pwm_out[15:8]), 32'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_pwm_out", 32'(pwm_out), 32'h0);
    chk("async_reset_period_start", 32'(period_start), 32'h0);
    @(posedge clk);
    #1;
    chk("held_reset_pwm_out", 32'(pwm_out), 32'h0);
    rst_n   = 1'b1;
    n_edges = 0;
`ifdef PWM_DUTY_SYNC_UPDATE_EN
    duty_sh = 8'h00;
`endif
    measure(len, hi);
    chk("first_ps_after_reset", len, Period);

    // Static mode and enable latency.
    set_en(16'hFFFF, 16'h0000);
    step();
    chk("static_all", 32'(pwm_out), 32'hFFFF);
    set_en(16'h00F0, 16'h0000);
    step();
    chk("static_00f0", 32'(pwm_out), 32'h00F0);

    // 50 % duty.
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    wait_ps();
    measure(len, hi);
    chk("duty50_period", len, Period);
    chk("duty50_high", hi, 128 * ClkDiv);

    // Duty change mid-pulse at pwm_cnt = 0x40.
    hi = 0;
    repeat (64 * ClkDiv) begin
      step();
      if (pwm_out[0]) hi++;
    end
    duty = 8'h10;
    step();
    if (pwm_out[0]) hi++;
`ifdef PWM_DUTY_SYNC_UPDATE_EN
    chk("dchg_no_truncate", 32'(pwm_out[0]), 32'd1);
`else
    chk("dchg_fall_1clk", 32'(pwm_out[0]), 32'd0);
`endif
    measure(len2, hi2);
    chk("dchg_period", len2 + 64 * ClkDiv + 1, Period);
`ifdef PWM_DUTY_SYNC_UPDATE_EN
    chk("dchg_cur_high", hi + hi2, 128 * ClkDiv);
`else
    chk("dchg_cur_high", hi + hi2, 64 * ClkDiv);
`endif
    measure(len, hi);
    chk("dchg_next_high", hi, 16 * ClkDiv);

    // Extremes.
    duty = 8'h00;
    wait_ps();
    measure(len, hi);
    chk("duty00_high", hi, 0);
    duty = 8'hFF;
    wait_ps();
    for (int p = 0; p < 3; p++) begin
      measure(len, hi);
      chk("dutyFF_high", hi, Period);
    end
    set_en(16'hFFFF, 16'h00FF);
    duty = 8'h00;
    wait_ps();
    step();
    chk("mixed_duty0", 32'(pwm_out), 32'hFF00);

    // Random configuration changes against the model.
    for (int k = 0; k < 8000; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 4))
          0:       eo_lo = 8'($urandom);
          1:       eo_hi = 8'($urandom);
          2:       ep_lo = 8'($urandom);
          3:       ep_hi = 8'($urandom);
          default: duty  = 8'($urandom);
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
